// File: rtl/input_capture.sv
`default_nettype none
// ============================================================================
//  Module      : input_capture
//  Description : Synchronises and debounces raw joystick / push-button pins,
//                encodes them into SIZE-bit words and emits one-cycle write
//                strobes towards the data memory input slots whenever an
//                encoded word changes, plus one strobe right after reset.
//                Optional feature macro: INPUT_REFRESH_EN (periodic re-write
//                of both slots every REFRESH_CYCLES cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module input_capture #(
    parameter int SIZE            = 16,
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REFRESH_CYCLES  = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             joy_raw,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [SIZE-1:0]        input0_write_data,
    output logic                   input0_write_en,
    output logic [SIZE-1:0]        input1_write_data,
    output logic                   input1_write_en
);

    // Joystick occupies bits [3:0] of the internal vectors, buttons sit above.
    localparam int NBITS = 4 + NUM_BUTTONS;
    localparam int CW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the encoders and counters cannot represent.
    generate
        if (SIZE < 3 || SIZE < NUM_BUTTONS || DEBOUNCE_CYCLES < 1 || REFRESH_CYCLES < 2) begin : g_param_check
            $error("input_capture: illegal parameter combination");
        end
    endgenerate

    logic [NBITS-1:0] meta_q;
    logic [NBITS-1:0] sync_q;
    logic [NBITS-1:0] stable_q;
    logic [NBITS-1:0] stable_d;
    logic [CW-1:0]    cnt_q [NBITS];
    logic [CW-1:0]    cnt_d [NBITS];
    logic [SIZE-1:0]  joy_word;
    logic [SIZE-1:0]  btn_word;
    logic             init_q;
    logic             refresh_wrap;

    // Two-flop synchroniser for every asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {btn_raw, joy_raw};
            sync_q <= meta_q;
        end
    end

    // Debounce next-state: a differing level must persist DEBOUNCE_CYCLES
    // consecutive cycles; any return to the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NBITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Fixed-priority joystick code: up, down, left, right; none gives 0.
    always_comb begin
        joy_word = '0;
        if (stable_q[3]) begin
            joy_word = SIZE'(1);
        end else if (stable_q[2]) begin
            joy_word = SIZE'(2);
        end else if (stable_q[1]) begin
            joy_word = SIZE'(3);
        end else if (stable_q[0]) begin
            joy_word = SIZE'(4);
        end
    end

    // Button word is the raw stable levels, zero-extended.
    always_comb begin
        btn_word                  = '0;
        btn_word[NUM_BUTTONS-1:0] = stable_q[NBITS-1:4];
    end

`ifdef INPUT_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

    logic [RW-1:0] refresh_q;
    logic [RW-1:0] refresh_d;

    // Free-running refresh period counter, independent of change strobes.
    always_comb begin
        refresh_wrap = (refresh_q == REF_LAST);
        refresh_d    = refresh_wrap ? '0 : refresh_q + 1'b1;
    end

    // Refresh counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    // Without refresh, strobes come only from changes and the init flag.
    always_comb begin
        refresh_wrap = 1'b0;
    end
`endif

    // Init flag forces one strobe on both channels after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= 1'b1;
        end else begin
            init_q <= 1'b0;
        end
    end

    // Output registers: reload every cycle, strobe on change, init or refresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input0_write_data <= '0;
            input0_write_en   <= 1'b0;
            input1_write_data <= '0;
            input1_write_en   <= 1'b0;
        end else begin
            input0_write_data <= joy_word;
            input0_write_en   <= init_q | refresh_wrap | (joy_word != input0_write_data);
            input1_write_data <= btn_word;
            input1_write_en   <= init_q | refresh_wrap | (btn_word != input1_write_data);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_capture
//  Description : Self-checking bench for input_capture with a history-window
//                reference model and directed plus randomized pin activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_capture;

    localparam int SIZE  = 16;
    localparam int NB    = 4;
    localparam int DEB   = 4;
    localparam int REF   = 8;
    localparam int NBITS = 4 + NB;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [3:0]      joy_raw = '0;
    logic [NB-1:0]   btn_raw = '0;
    logic [SIZE-1:0] input0_write_data;
    logic            input0_write_en;
    logic [SIZE-1:0] input1_write_data;
    logic            input1_write_en;

    int checks = 0;
    int errors = 0;
    int cnt0, cnt1, cnt_both;

    input_capture #(
        .SIZE            (SIZE),
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DEB),
        .REFRESH_CYCLES  (REF)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .joy_raw           (joy_raw),
        .btn_raw           (btn_raw),
        .input0_write_data (input0_write_data),
        .input0_write_en   (input0_write_en),
        .input1_write_data (input1_write_data),
        .input1_write_en   (input1_write_en)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [NBITS-1:0] m_rq[$];
    logic [NBITS-1:0] m_hist[$];
    logic [NBITS-1:0] m_stable;
    logic [NBITS-1:0] m_din;
    logic [SIZE-1:0]  m_d0, m_d1, m_w0, m_w1;
    logic             m_e0, m_e1;
    bit               m_init, m_refresh, m_all;
    int               m_edges;

    function automatic logic [SIZE-1:0] joy_code(input logic [3:0] j);
        if (j[3])      return SIZE'(1);
        else if (j[2]) return SIZE'(2);
        else if (j[1]) return SIZE'(3);
        else if (j[0]) return SIZE'(4);
        return '0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rq = {};
            m_rq.push_back('0);
            m_rq.push_back('0);
            m_hist   = {};
            m_stable = '0;
            m_d0 = '0; m_d1 = '0; m_e0 = 1'b0; m_e1 = 1'b0;
            m_init = 1'b1;
            m_edges = 0;
        end else begin
            m_w0 = joy_code(m_stable[3:0]);
            m_w1 = SIZE'(m_stable[NBITS-1:4]);
`ifdef INPUT_REFRESH_EN
            m_refresh = ((m_edges % REF) == REF - 1);
`else
            m_refresh = 1'b0;
`endif
            m_e0 = m_init || m_refresh || (m_w0 != m_d0);
            m_e1 = m_init || m_refresh || (m_w1 != m_d1);
            m_d0 = m_w0;
            m_d1 = m_w1;
            m_init = 1'b0;
            m_edges++;
            // Level seen by the debouncer is the pin value from two edges ago.
            m_din = m_rq.pop_front();
            m_rq.push_back({btn_raw, joy_raw});
            m_hist.push_back(m_din);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            // A bit flips once its last DEB observed levels all disagree with it.
            if (m_hist.size() == DEB) begin
                for (int b = 0; b < NBITS; b++) begin
                    m_all = 1'b1;
                    foreach (m_hist[k]) if (m_hist[k][b] == m_stable[b]) m_all = 1'b0;
                    if (m_all) m_stable[b] = ~m_stable[b];
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, comparing every output against the model at each negedge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("data0", 32'(input0_write_data), 32'(m_d0));
            chk("en0",   32'(input0_write_en),   32'(m_e0));
            chk("data1", 32'(input1_write_data), 32'(m_d1));
            chk("en1",   32'(input1_write_en),   32'(m_e1));
            cnt0     += int'(input0_write_en);
            cnt1     += int'(input1_write_en);
            cnt_both += int'(input0_write_en & input1_write_en);
        end
    endtask

    task automatic clr_counts();
        cnt0 = 0; cnt1 = 0; cnt_both = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clr_counts();
        #1 rst = 1'b1;
        step(3);
        chk("reset_data0", 32'(input0_write_data), 32'h0);
        chk("reset_en0",   32'(input0_write_en),   32'h0);
        chk("reset_en1",   32'(input1_write_en),   32'h0);

        // Reset release: single init strobe on both channels with zero data.
        rst = 1'b0;
        step(1);
        chk("init_en0",   32'(input0_write_en),   32'h1);
        chk("init_en1",   32'(input1_write_en),   32'h1);
        chk("init_data1", 32'(input1_write_data), 32'h0);
        step(1);
        chk("init_end_en0", 32'(input0_write_en), 32'h0);
        step(4);

        // Up press.
        clr_counts();
        joy_raw = 4'b1000;
        step(12);
        chk("up_cnt0",  32'(cnt0), 32'd1);
        chk("up_cnt1",  32'(cnt1), 32'd0);
        chk("up_data0", 32'(input0_write_data), 32'h1);

        // Glitch shorter than the debounce window.
        clr_counts();
        btn_raw = 4'b0010;
        step(3);
        btn_raw = '0;
        step(10);
        chk("glitch_cnt1", 32'(cnt1), 32'd0);
        clr_counts();
        btn_raw = 4'b0010;
        step(10);
        chk("held_cnt1",  32'(cnt1), 32'd1);
        chk("held_data1", 32'(input1_write_data), 32'h2);

        // Priority: left under held up produces no strobe; releasing up does.
        clr_counts();
        joy_raw = 4'b1010;
        step(10);
        chk("prio_cnt0", 32'(cnt0), 32'd0);
        clr_counts();
        joy_raw = 4'b0010;
        step(10);
        chk("prio_rel_cnt0",  32'(cnt0), 32'd1);
        chk("prio_rel_data0", 32'(input0_write_data), 32'h3);

        // Simultaneous changes on both channels.
        joy_raw = '0; btn_raw = '0;
        step(12);
        clr_counts();
        joy_raw = 4'b0001; btn_raw = 4'b0001;
        step(12);
        chk("simul_both",  32'(cnt_both), 32'd1);
        chk("simul_data0", 32'(input0_write_data), 32'h4);
        chk("simul_data1", 32'(input1_write_data), 32'h1);

        // Reset asserted mid-debounce, asynchronously between edges.
        joy_raw = 4'b1000;
        step(3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_data0", 32'(input0_write_data), 32'h0);
        chk("midrst_data1", 32'(input1_write_data), 32'h0);
        chk("midrst_en0",   32'(input0_write_en),   32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("midrst_init_en0", 32'(input0_write_en), 32'h1);
        chk("midrst_init_en1", 32'(input1_write_en), 32'h1);
        step(12);

        // Idle window: periodic strobes only when refresh is built in.
        joy_raw = '0; btn_raw = '0;
        step(12);
        clr_counts();
        step(5 * REF);
`ifdef INPUT_REFRESH_EN
        chk("idle_refresh_cnt0", 32'(cnt0), 32'd5);
        chk("idle_refresh_cnt1", 32'(cnt1), 32'd5);
`else
        chk("idle_cnt0", 32'(cnt0), 32'd0);
        chk("idle_cnt1", 32'(cnt1), 32'd0);
`endif

        // Randomized pin activity with hold times around the debounce window.
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                joy_raw = 4'($urandom);
                btn_raw = NB'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                joy_raw[$urandom_range(0, 3)] ^= 1'b1;
            end else begin
                btn_raw[$urandom_range(0, NB - 1)] ^= 1'b1;
            end
            step($urandom_range(1, 2 * DEB + 3));
        end
        step(2 * DEB + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_capture.md
# input_capture

Front-end stage feeding the data memory's two input-slot write ports. Synchronises and debounces the raw joystick and push-button pins, encodes them into SIZE-bit words, and issues one-cycle write strobes on `input0_write_en` / `input1_write_en` whenever a debounced word changes. It also issues one strobe after reset, so the joystick and button slots always hold the live input state.

## Interface
- `SIZE`, 16: width of each output word. Must be at least 3 and at least `NUM_BUTTONS`.
- `NUM_BUTTONS`, 4: number of push buttons.
- `DEBOUNCE_CYCLES`, 500000: cycles a new synchronised level must hold before it is accepted. Minimum 1.
- `REFRESH_CYCLES`, 1000000: refresh period. Used only with `INPUT_REFRESH_EN`. Minimum 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `joy_raw` input 4: raw joystick pins, asynchronous. Bit 3 = up, 2 = down, 1 = left, 0 = right. 1 = pressed.
- `btn_raw` input `NUM_BUTTONS`: raw button pins, asynchronous. 1 = pressed.
- `input0_write_data` output `SIZE`: joystick word, registered.
- `input0_write_en` output 1: joystick write strobe, registered.
- `input1_write_data` output `SIZE`: button word, registered.
- `input1_write_en` output 1: button write strobe, registered.

## Operation
- **Synchroniser:** a 2-flop synchroniser on each of the `4 + NUM_BUTTONS` raw bits.
- **Debounce, per bit:** one stable register and one counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If the synchronised bit equals the stable bit, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the bit still differs, the stable bit takes the new level and the counter clears.
  - A bounce back to the stable level before then clears the counter with no update.
- **Joystick encoding, fixed priority:** up=1, then down=2, then left=3, then right=4; none=0. Bits `[SIZE-1:3]` are 0. Opposite directions held together resolve by priority (up+down gives 1).
- **Button encoding:** bits `[NUM_BUTTONS-1:0]` are the stable levels; the upper bits are 0.
- **Change detect:** each output register is compared with its combinational encoded word.
  - On inequality: load the word and assert the matching `_write_en` for one cycle.
  - A stable-bit change that leaves the encoded word unchanged (e.g. left pressed while up held) produces no strobe.
- **Channel independence:** the joystick and button channels are independent. Simultaneous changes give both strobes in the same cycle.
- **Init flag:** resets to 1. On the first edge after `rst` deasserts, both strobes are asserted with the current encoded words (0 unless a pin already debounced, which is impossible that early). The flag then clears.
- **No strobe suppression:** the block has no knowledge of CPU writes. Data memory gives its regular port precedence on address collisions, so a strobe that coincides with a CPU write to the same slot is lost. It is not retried unless `INPUT_REFRESH_EN` is defined.

## Timing
- **Reset values:** all outputs 0; all synchroniser, stable and counter state 0; init flag 1. Reset asserted mid-debounce or mid-strobe clears everything immediately.
- **Latency:** a raw level change first sampled at edge E, and held, updates the stable bit at edge E+1+`DEBOUNCE_CYCLES`. The data word and strobe update at edge E+2+`DEBOUNCE_CYCLES`, so the strobe is high for the cycle after that edge.
- **Strobe shape:** at most one cycle long. Back-to-back strobes are impossible for the same bit; they are possible for different bits on the same channel.
- **Data hold:** `_write_data` holds its value between strobes.

## Configuration
- **`INPUT_REFRESH_EN` defined:**
  - A free-running counter (reset 0) wraps at `REFRESH_CYCLES-1`.
  - On the wrap cycle both strobes are asserted with the current encoded words, restoring slots overwritten by CPU writes.
  - A change coinciding with a refresh produces a single strobe carrying the new word.
  - The counter is not reset by change strobes.
- **`INPUT_REFRESH_EN` undefined:** no refresh counter exists; strobes occur only on change and after reset.

## Test plan
- **Reset release:** `rst` 1→0 with all pins low → both strobes high for exactly one cycle with data 0x0000, then low.
- **Up press:** `DEBOUNCE_CYCLES`=4, `joy_raw`=4'b1000 held → `input0_write_en` pulses once with 0x0001 at sample edge +6; `input1_write_en` stays 0.
- **Glitch rejection:** `DEBOUNCE_CYCLES`=4, `btn_raw`=4'b0010 for 3 cycles then 0 → no strobe. The same pattern held for 10 cycles → one strobe with 0x0002.
- **Priority:** up held (word 1), then left also pressed → no strobe. Up released → strobe with 0x0003.
- **Simultaneous changes and reset:** button 0 and right pressed on the same cycle → both strobes in the same cycle, data 0x0001 and 0x0004. `rst` pulsed mid-debounce → outputs 0, then the init strobe follows.
- **Refresh, `INPUT_REFRESH_EN` only:** `REFRESH_CYCLES`=8, pins idle → both strobes every 8 cycles. With the macro undefined → no periodic strobes.
